// File: rtl/div_pkg.sv
// div_pkg: shared constants and FSM state type for the iterative signed divider
package div_pkg;
    localparam int WIDTH = 32;
    localparam int LATENCY = 33;
    localparam int COUNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring radix-2 iteration on unsigned magnitudes
module div_step
    import div_pkg::*;
(
    input  logic [WIDTH:0]   i_r,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH:0]   o_r,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_ge;
    logic           w_unused;
    // R[32] is always 0 between steps because R stays below |B| <= 2^31
    assign w_unused = i_r[WIDTH];
    // Shift in the next dividend bit, trial-subtract, keep the difference if it did not borrow
    always_comb begin
        w_shift = {i_r[WIDTH-1:0], i_q[WIDTH-1]};
        w_diff  = w_shift - {1'b0, i_b};
        w_ge    = w_shift >= {1'b0, i_b};
        o_r     = w_ge ? w_diff : w_shift;
        o_q     = {i_q[WIDTH-2:0], w_ge};
    end
endmodule

// File: rtl/div32_iter.sv
// div32_iter: multi-cycle signed 32-bit divider, one quotient bit per cycle with sign fix-up
module div32_iter
    import div_pkg::*;
#(
    parameter bit EARLY_DBZ = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    state_t             r_state;
    state_t             w_next;
    logic [COUNT_W-1:0] r_count;
    logic [WIDTH:0]     r_r;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_a;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_dbz;
    logic               r_exc;
    logic [WIDTH:0]     w_r_next;
    logic [WIDTH-1:0]   w_q_next;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_b_zero;
    assign w_abs_a  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_abs_b  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign w_b_zero = data_operandB == '0;
    div_step u_step (
        .i_r (r_r),
        .i_q (r_q),
        .i_b (r_b),
        .o_r (w_r_next),
        .o_q (w_q_next)
    );
    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end
    // Next state: a start always wins, including an abort of a running divide
    always_comb begin
        w_next = r_state;
        w_next = ctrl_div ? ((EARLY_DBZ && w_b_zero) ? FIX : ITER)
               : (r_state == ITER && r_count == COUNT_W'(WIDTH - 1)) ? FIX
               : (r_state == FIX) ? IDLE : r_state;
    end
    // Operand capture, iteration datapath and registered results
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count        <= '0;
            r_r            <= '0;
            r_q            <= '0;
            r_b            <= '0;
            r_a            <= '0;
            r_sign_a       <= 1'b0;
            r_sign_b       <= 1'b0;
            r_dbz          <= 1'b0;
            r_exc          <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_div) begin
                r_count  <= '0;
                r_r      <= '0;
                r_q      <= w_abs_a;
                r_b      <= w_abs_b;
                r_a      <= data_operandA;
                r_sign_a <= data_operandA[WIDTH-1];
                r_sign_b <= data_operandB[WIDTH-1];
                r_dbz    <= w_b_zero;
                r_exc    <= w_b_zero || (data_operandA == INT_MIN && data_operandB == '1);
                busy     <= 1'b1;
            end else if (r_state == ITER) begin
                r_r     <= w_r_next;
                r_q     <= w_q_next;
                r_count <= r_count + 1'b1;
            end else if (r_state == FIX) begin
                data_result    <= r_dbz ? '0 : ((r_sign_a ^ r_sign_b) ? -r_q : r_q);
                data_remainder <= r_dbz ? r_a : (r_sign_a ? -r_r[WIDTH-1:0] : r_r[WIDTH-1:0]);
                data_exception <= r_exc;
                data_resultRDY <= 1'b1;
                busy           <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_div32_iter.sv
// tb_div32_iter: scoreboard bench for div32_iter with early and full-latency divide-by-zero variants
module tb_div32_iter;
    import div_pkg::*;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
        int          at;
    } exp_t;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_div = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] e_q, e_r, l_q, l_r;
    logic        e_exc, e_rdy, e_busy, l_exc, l_rdy, l_busy;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb_e[$];
    exp_t        sb_l[$];
    div32_iter #(.EARLY_DBZ(1'b1)) dut_e (
        .clock(clock), .reset_n(reset_n), .ctrl_div(ctrl_div),
        .data_operandA(a), .data_operandB(b),
        .data_result(e_q), .data_remainder(e_r), .data_exception(e_exc),
        .data_resultRDY(e_rdy), .busy(e_busy)
    );
    div32_iter #(.EARLY_DBZ(1'b0)) dut_l (
        .clock(clock), .reset_n(reset_n), .ctrl_div(ctrl_div),
        .data_operandA(a), .data_operandB(b),
        .data_result(l_q), .data_remainder(l_r), .data_exception(l_exc),
        .data_resultRDY(l_rdy), .busy(l_busy)
    );
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;
    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached with %0d checks", checks);
        $fatal(1, "watchdog");
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // Early-DBZ instance monitor
    always @(negedge clock) begin
        if (e_rdy) begin
            if (sb_e.size() == 0) check("early_unexpected_rdy", 32'd1, 32'd0);
            else begin
                exp_t x;
                x = sb_e.pop_front();
                check("early_q", e_q, x.q);
                check("early_r", e_r, x.r);
                check("early_exc", {31'd0, e_exc}, {31'd0, x.exc});
                check("early_rdy_cycle", cyc, x.at);
            end
        end
    end
    // Full-latency instance monitor
    always @(negedge clock) begin
        if (l_rdy) begin
            if (sb_l.size() == 0) check("late_unexpected_rdy", 32'd1, 32'd0);
            else begin
                exp_t x;
                x = sb_l.pop_front();
                check("late_q", l_q, x.q);
                check("late_r", l_r, x.r);
                check("late_exc", {31'd0, l_exc}, {31'd0, x.exc});
                check("late_rdy_cycle", cyc, x.at);
            end
        end
    end
    task automatic start(input logic [31:0] av, input logic [31:0] bv, output int e0);
        @(negedge clock);
        ctrl_div = 1'b1;
        a = av;
        b = bv;
        e0 = cyc + 1;
        @(negedge clock);
        ctrl_div = 1'b0;
    endtask
    task automatic start_exp(input logic [31:0] av, input logic [31:0] bv,
                             input logic [31:0] q, input logic [31:0] r, input logic exc, output int e0);
        @(negedge clock);
        ctrl_div = 1'b1;
        a = av;
        b = bv;
        e0 = cyc + 1;
        sb_e.push_back('{q, r, exc, e0 + ((bv == 0) ? 1 : LATENCY)});
        sb_l.push_back('{q, r, exc, e0 + LATENCY});
        @(negedge clock);
        ctrl_div = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while ((sb_e.size() != 0 || sb_l.size() != 0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", n, (n < 200) ? n : 0);
        repeat (2) @(negedge clock);
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_e_out"}, e_q | e_r, 32'd0);
        check({tag, "_e_flags"}, {29'd0, e_exc, e_rdy, e_busy}, 32'd0);
        check({tag, "_l_out"}, l_q | l_r, 32'd0);
        check({tag, "_l_flags"}, {29'd0, l_exc, l_rdy, l_busy}, 32'd0);
    endtask
    initial begin
        int e0;
        repeat (3) @(negedge clock);
        check_zero("reset");
        reset_n = 1'b1;
        start_exp(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, e0);
        check("busy_at_e0", {31'd0, e_busy}, 32'd1);
        while (cyc < e0 + 32) @(negedge clock);
        check("busy_at_e32", {31'd0, e_busy}, 32'd1);
        check("rdy_low_at_e32", {31'd0, e_rdy}, 32'd0);
        @(negedge clock);
        check("busy_low_at_e33", {31'd0, e_busy}, 32'd0);
        drain();
        start_exp(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, e0);
        drain();
        start_exp(32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, e0);
        drain();
        start_exp(-32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE, 1'b0, e0);
        drain();
        start_exp(32'd7, 32'd0, 32'd0, 32'd7, 1'b1, e0);
        drain();
        start_exp(-32'sd7, 32'd0, 32'd0, 32'hFFFF_FFF9, 1'b1, e0);
        drain();
        start_exp(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, e0);
        drain();
        start_exp(32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, e0);
        drain();
        start_exp(32'h8000_0000, 32'd7, 32'hEDB6_DB6E, 32'hFFFF_FFFE, 1'b0, e0);
        drain();
        start_exp(32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0, e0);
        drain();
        start_exp(32'd5, 32'd100, 32'd0, 32'd5, 1'b0, e0);
        drain();
        start(32'd100, 32'd7, e0);
        while (cyc < e0 + 9) @(negedge clock);
        start_exp(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, e0);
        drain();
        start(32'd100, 32'd7, e0);
        while (cyc < e0 + 4) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check_zero("midrun_reset");
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        check("no_rdy_after_reset", sb_e.size() + sb_l.size(), 32'd0);
        start_exp(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, e0);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
